// File: rtl/alu_pkg.sv
// Shared ALUControl code table and FSM encoding for the ALU decoder and
// the iterative ALU, so both sides agree on one set of codes.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   function automatic logic is_shift(input logic [2:0] code);
      return (code == ALU_SLL) || (code == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU operations: add/sub/and/or/xor/slt. Shift codes yield 0;
// shifts are handled bit-serially by the enclosing block.
module alu_comb_ops
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ALUControl,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             slt;

   assign sum  = a + b;
   assign diff = a - b;
   // Signed less-than: when signs differ the sign of a decides, avoiding overflow.
   assign slt  = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];

   always_comb begin
      result = '0;
      case (ALUControl)
         ALU_ADD: result = sum;
         ALU_SUB: result = diff;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_iterative.sv
// Multicycle-core ALU: one-cycle logic/arith/compare, bit-serial shifts.
// Handshake: start is accepted on a rising edge where start & ready; done pulses once when result is valid.
module alu_iterative
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ALUControl,
   output logic             ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             done
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted;
   logic [SHW-1:0]   cnt;
   logic [SHW-1:0]   shamt;
   logic             shift_left;
   logic [WIDTH-1:0] comb_result;
   logic             accept;

   alu_comb_ops #(.WIDTH(WIDTH)) u_comb_ops (
      .a          (a),
      .b          (b),
      .ALUControl (ALUControl),
      .result     (comb_result)
   );

   assign shamt   = b[SHW-1:0];
   assign accept  = start && (state == S_IDLE);
   assign shifted = shift_left ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
   assign zero    = (result == '0);

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               if (is_shift(ALUControl) && (shamt != '0)) state_next = S_SHIFT;
               else                                       state_next = S_DONE;
            end
         end
         S_SHIFT: begin
            if (cnt == SHW'(1)) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         result     <= '0;
         shreg      <= '0;
         cnt        <= '0;
         shift_left <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            if (!is_shift(ALUControl)) begin
               result <= comb_result;
            end else if (shamt == '0) begin
               result <= a;
            end else begin
               shreg      <= a;
               cnt        <= shamt;
               shift_left <= (ALUControl == ALU_SLL);
            end
         end else if (state == S_SHIFT) begin
            shreg <= shifted;
            cnt   <= cnt - SHW'(1);
            // result only changes on the final shift step; it holds the previous value until then
            if (cnt == SHW'(1)) result <= shifted;
         end
      end
   end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed plus random checks of alu_iterative: results, zero flag, latency,
// handshake behaviour with start held high, and asynchronous reset mid-shift.
module tb_alu_iterative;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   ALUControl;
   logic         ready;
   logic [W-1:0] result;
   logic         zero;
   logic         done;

   logic [W-1:0] exp_q[$];
   int           errors = 0;
   int           checks = 0;

   alu_iterative #(.WIDTH(W), .SHW(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .a          (a),
      .b          (b),
      .ALUControl (ALUControl),
      .ready      (ready),
      .result     (result),
      .zero       (zero),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
      case (c)
         3'd0: return x + y;
         3'd1: return x - y;
         3'd2: return x & y;
         3'd3: return x | y;
         3'd4: return x ^ y;
         3'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         3'd6: return x << y[4:0];
         default: return x >> y[4:0];
      endcase
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] op_a,
                        input logic [W-1:0] op_b, input logic [W-1:0] exp, input int exp_lat);
      int lat;
      int nrdy;
      logic [W-1:0] want;
      check({tag, "_ready_idle"}, ready, 1);
      ALUControl = op;
      a          = op_a;
      b          = op_b;
      start      = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      start      = 1'b0;
      a          = $urandom;
      b          = $urandom;
      ALUControl = 3'($urandom_range(0, 7));
      lat  = 1;
      nrdy = 0;
      while (!done && lat < 40) begin
         if (!ready) nrdy++;
         @(negedge clk);
         lat++;
      end
      want = exp_q.pop_front();
      check({tag, "_done_seen"}, done, 1);
      if (done) begin
         check({tag, "_latency"}, lat, exp_lat);
         check({tag, "_result"}, result, want);
         check({tag, "_zero"}, zero, (want == 0));
         check({tag, "_busy_cycles"}, nrdy, exp_lat - 1);
         check({tag, "_ready_in_done"}, ready, 0);
      end
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_ready_after"}, ready, 1);
   endtask

   initial begin
      int n_done;
      logic [2:0] rc;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      reset      = 1'b1;
      start      = 1'b0;
      a          = '0;
      b          = '0;
      ALUControl = ALU_ADD;
      repeat (2) @(negedge clk);
      check("rst_result", result, 0);
      check("rst_ready", ready, 1);
      check("rst_zero", zero, 1);
      check("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clk);

      do_op("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1);
      do_op("sub_eq", ALU_SUB, 32'd3, 32'd3, 32'd0, 1);
      do_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
      do_op("slt_ovf", ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1);
      do_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
      do_op("and", ALU_AND, 32'hF0F0_1234, 32'hFF00_FF0F, 32'hF000_1204, 1);
      do_op("or", ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
      do_op("xor", ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
      do_op("sll31", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 32);
      do_op("srl4", ALU_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 5);
      do_op("srl0", ALU_SRL, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1);

      for (int i = 0; i < 12; i++) begin
         rc = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         do_op("rand", rc, ra, rb, ref_alu(rc, ra, rb),
               (rc >= 3'd6 && rb[4:0] != 0) ? int'(rb[4:0]) + 1 : 1);
      end

      // start held high with changing operands during a 10-step sll
      ALUControl = ALU_SLL;
      a          = 32'd3;
      b          = 32'd10;
      start      = 1'b1;
      exp_q.push_back(32'd3072);
      @(posedge clk);
      n_done = 0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (done) n_done++;
         if (k < 11) begin
            a          = $urandom;
            b          = $urandom;
            ALUControl = 3'($urandom_range(0, 7));
         end
      end
      check("hold_done_c11", done, 1);
      check("hold_result", result, exp_q.pop_front());
      ALUControl = ALU_ADD;
      a          = 32'd100;
      b          = 32'd23;
      exp_q.push_back(32'd123);
      @(negedge clk);
      check("hold_idle_no_done", done, 0);
      check("hold_idle_ready", ready, 1);
      check("hold_single_done", n_done, 1);
      @(negedge clk);
      start = 1'b0;
      check("hold_next_done", done, 1);
      check("hold_next_result", result, exp_q.pop_front());
      @(negedge clk);

      // asynchronous reset in the middle of a shift (cnt = 7)
      ALUControl = ALU_SLL;
      a          = 32'hFF;
      b          = 32'd10;
      start      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_shift_busy", ready, 0);
      #2 reset = 1'b1;
      #1;
      check("async_rst_result", result, 0);
      check("async_rst_done", done, 0);
      check("async_rst_ready", ready, 1);
      check("async_rst_zero", zero, 1);
      @(negedge clk);
      reset  = 1'b0;
      n_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("aborted_no_done", n_done, 0);
      check("aborted_result", result, 0);
      do_op("add_after_rst", ALU_ADD, 32'd40, 32'd2, 32'd42, 1);

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
